// File: rtl/cory_arb3.sv
// cory_arb3: three-input round-robin arbiter with packet locking.
// Merges three valid/ready streams into one registered output slot. A packet
// that starts on one source (l=0 beat) keeps the channel until its l=1 beat.
// Each output beat carries its source index in o_z_s.
//
// Ports:
//   clk, reset_n            clock, async active-low reset
//   i_ak_v/i_ak_d/i_ak_l    requester k valid / data / last (k = 0..2)
//   o_ak_r                  ready to requester k (combinational)
//   o_z_v/o_z_d/o_z_l/o_z_s registered output valid / data / last / source
//   i_z_r                   downstream ready
//   o_lock                  packet in progress (registered)
module cory_arb3 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_a0_v,
  input  logic [N-1:0] i_a0_d,
  input  logic         i_a0_l,
  output logic         o_a0_r,
  input  logic         i_a1_v,
  input  logic [N-1:0] i_a1_d,
  input  logic         i_a1_l,
  output logic         o_a1_r,
  input  logic         i_a2_v,
  input  logic [N-1:0] i_a2_d,
  input  logic         i_a2_l,
  output logic         o_a2_r,
  output logic         o_z_v,
  output logic [N-1:0] o_z_d,
  output logic         o_z_l,
  output logic [1:0]   o_z_s,
  input  logic         i_z_r,
  output logic         o_lock
);
  localparam int NSRC = 3;

  logic [NSRC-1:0]        req_v;
  logic [NSRC-1:0][N-1:0] req_d;
  logic [NSRC-1:0]        req_l;
  logic [NSRC-1:0]        rdy;

  assign req_v = {i_a2_v, i_a1_v, i_a0_v};
  assign req_d = {i_a2_d, i_a1_d, i_a0_d};
  assign req_l = {i_a2_l, i_a1_l, i_a0_l};

  logic [1:0] ptr, lsrc;
  logic       lock;
  logic       ld, go;
  logic [1:0] gnt, cand;
  logic       gnt_v;

  function automatic logic [1:0] add_mod3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
  endfunction

  // Slot can take a new beat when empty or draining this cycle.
  assign ld = !o_z_v || i_z_r;

  // Scan from farthest to nearest so the nearest valid source (ptr first) wins.
  always_comb begin
    gnt   = ptr;
    gnt_v = 1'b0;
    cand  = ptr;
    if (lock) begin
      gnt   = lsrc;
      gnt_v = req_v[lsrc];
    end else begin
      for (int i = NSRC - 1; i >= 0; i--) begin
        cand = add_mod3(ptr, 2'(i));
        if (req_v[cand]) begin
          gnt   = cand;
          gnt_v = 1'b1;
        end
      end
    end
  end

  // Reset gates the ready path so nothing is accepted while reset is held.
  assign go = reset_n && ld && gnt_v;

  for (genvar k = 0; k < NSRC; k++) begin : g_rdy
    assign rdy[k] = go && (gnt == 2'(k));
  end

  assign o_a0_r = rdy[0];
  assign o_a1_r = rdy[1];
  assign o_a2_r = rdy[2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_z_v <= 1'b0;
      o_z_d <= '0;
      o_z_l <= 1'b0;
      o_z_s <= 2'd0;
      ptr   <= 2'd0;
      lock  <= 1'b0;
      lsrc  <= 2'd0;
    end else if (go) begin
      o_z_v <= 1'b1;
      o_z_d <= req_d[gnt];
      o_z_l <= req_l[gnt];
      o_z_s <= gnt;
      if (req_l[gnt]) begin
        lock <= 1'b0;
        ptr  <= add_mod3(gnt, 2'd1);
      end else begin
        lock <= 1'b1;
        lsrc <= gnt;
      end
    end else if (ld) begin
      o_z_v <= 1'b0;
    end
  end

  assign o_lock = lock;

endmodule

// File: doc/cory_arb3.md
# cory_arb3

Three-input round-robin arbiter that merges three valid/ready streams into one registered output stream. It is the fan-in counterpart of the three-way duplicator. It shares a single downstream channel among three requesters, with packet locking so multi-beat transfers are never interleaved. Each output beat carries the index of its source.

## Interface
Parameters:
- N, 8, data width of every input and of the output.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i_a0_v / i_a1_v / i_a2_v  in  1  requester k valid.
- i_a0_d / i_a1_d / i_a2_d  in  N  requester k data.
- i_a0_l / i_a1_l / i_a2_l  in  1  requester k last-beat flag; tie 1 for single-beat traffic.
- o_a0_r / o_a1_r / o_a2_r  out  1  ready to requester k.
- o_z_v  out  1  output valid (registered).
- o_z_d  out  N  output data (registered).
- o_z_l  out  1  output last flag (registered).
- o_z_s  out  2  source index of the current output beat, 0..2 (registered).
- i_z_r  in  1  downstream ready.
- o_lock  out  1  high while a packet is in progress (registered).

## Operation
- State: output slot {o_z_v, o_z_d, o_z_l, o_z_s}, round-robin pointer ptr (0..2), lock flag and lock source lsrc (0..2).
- Slot load enable: ld = !o_z_v || i_z_r.
- Grant (combinational):
  - If the lock is set, the candidate is lsrc only.
  - Otherwise, scan ptr, ptr+1, ptr+2 (mod 3) and take the first source with i_ak_v=1.
  - No grant if there is no valid candidate.
- Ready generation:
  - o_ak_r = ld && (grant == k).
  - At most one o_ak_r is high in any cycle.
  - Ready may depend on valid. Valid must never depend on ready.
- Transfer from source k: i_ak_v && o_ak_r. The slot loads d, l and s=k, and o_z_v becomes 1.
- If ld=1 and no transfer occurs, o_z_v goes to 0. If ld=0, the slot holds: o_z_* stable.
- Lock handling:
  - A transfer with l=0 sets lock=1 and lsrc=k.
  - A transfer with l=1 clears lock.
  - While locked, other requesters are not served even if lsrc is idle. A locked source with i_v=0 stalls the output; no timeout.
- Pointer update:
  - A transfer with l=1 from source k sets ptr to (k+1) mod 3.
  - A transfer with l=0 leaves ptr unchanged.
- o_lock mirrors the lock flag.
- o_z_s never takes value 3.
- Reset values: o_z_v=0, o_z_d=0, o_z_l=0, o_z_s=0, o_lock=0, ptr=0, lsrc=0. All o_ak_r=0 during reset.
- Reset mid-packet drops the lock and the buffered beat. Upstream must restart the packet.

## Timing
- Latency: a beat accepted in cycle t appears on o_z_* in cycle t+1.
- Throughput: 1 beat/cycle when i_z_r=1 continuously. The slot drains and reloads in the same cycle.
- o_ak_r is combinational from i_z_r, the i_a*_v inputs and state. There is no register on the ready path.
- Fairness: with all three sources continuously valid and single-beat, the grant order is 0,1,2,0,1,2,...
- With i_z_r=0 and o_z_v=1, all o_ak_r are 0 and the output is held stable for any number of cycles.
- Simultaneous drain and load: the old beat leaves and the new beat is registered on the same edge, with no bubble.

## Test plan
- Reset: assert reset_n=0 with random inputs. Require o_z_v=0, o_z_d=0, o_z_s=0, o_lock=0 and all o_ak_r=0. Release; the first grant with all valid goes to a0.
- Round-robin: a0/a1/a2 hold d=0x10/0x20/0x30 with l=1, all valid, i_z_r=1. Output sequence 0x10,0x20,0x30,0x10..., s=0,1,2,0. The first beat appears 1 cycle after the a0 transfer.
- Packet lock: a1 sends 0xA1(l=0), 0xA2(l=0), 0xA3(l=1) while a0 and a2 are valid (ptr=1). Output is 0xA1,0xA2,0xA3 contiguous with o_lock=1 during the packet, then a2 beat, then a0 beat. Also insert a 2-cycle a1 valid gap mid-packet: o_z_v drops and no other source is granted.
- Backpressure: fill the slot with 0x55, then i_z_r=0 for 5 cycles with all sources valid. o_z_d stays 0x55, o_z_v=1 and all o_ak_r=0. Raise i_z_r: next beats follow round-robin with no loss or duplication.
- Pointer wrap: only a2 sends one beat (l=1), then all sources valid. Next grant is a0 (ptr=0).
- Reset mid-packet: a0 sends l=0 (o_lock=1), then pulse reset_n low. Require o_lock=0, o_z_v=0, ptr=0. After release with a1 and a2 valid, a1 is granted.
